// File: rtl/motor_speed_ctrl.sv
// motor_speed_ctrl: closed-loop PI speed regulator driving an H-bridge PWM.
// Each new speed sample runs a four-state update (IDLE -> ERR -> INTEG -> OUT).
// The resulting duty is loaded into the PWM generator only when its counter
// wraps, so a PWM period never sees two different duty values.
// Optional build macro: MOTOR_SLEW_LIMIT_EN. When it is defined, each update
// moves duty_next by at most SLEW_STEP toward the clamped controller output.
//
// state | meaning
// IDLE  | waiting for a sample_valid strobe while enabled
// ERR   | compute error = target - measurement
// INTEG | accumulate the error into the clamped integrator
// OUT   | form the P+I output, clamp it, and update duty_next
module motor_speed_ctrl #(
    parameter int KP_SHIFT  = 1,
    parameter int KI_SHIFT  = 3,
    parameter int INT_MAX   = 1023,
    parameter int PWM_DIV   = 4,
    parameter int SLEW_STEP = 8
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] target_speed,
    input  logic [7:0] pulse_data,
    input  logic       sample_valid,
    output logic       pwm_out,
    output logic [7:0] duty,
    output logic       saturated,
    output logic       busy
);

    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    typedef enum logic [1:0] {IDLE, ERR, INTEG, OUT} state_t;

    state_t              r_state;
    logic [7:0]          r_meas;
    logic [7:0]          r_tgt;
    logic signed [8:0]   r_err;
    logic signed [11:0]  r_integ;
    logic [7:0]          r_duty_next;
    logic [7:0]          r_duty;
    logic [7:0]          r_pwm_cnt;
    logic [PW-1:0]       r_presc;
    logic                r_pwm_out;
    logic                r_sat;

    logic signed [12:0]  w_sum;
    logic signed [12:0]  w_lim;
    logic signed [13:0]  w_p;
    logic signed [13:0]  w_i;
    logic signed [13:0]  w_u;
    logic [7:0]          w_uc;
    logic                w_u_sat;
    logic [7:0]          w_dn_new;
    logic                w_tick;

    // Integrator sum is one bit wider than the integrator so the clamp sees true overflow.
    assign w_sum = {r_integ[11], r_integ} + {{4{r_err[8]}}, r_err};
    assign w_lim = 13'(INT_MAX);

    assign w_p = $signed({{5{r_err[8]}}, r_err}) <<< KP_SHIFT;
    assign w_i = $signed({{2{r_integ[11]}}, r_integ}) >>> KI_SHIFT;
    assign w_u = w_p + w_i;

    // Clamp controller output into the 8-bit duty range.
    always_comb begin
        w_uc    = w_u[7:0];
        w_u_sat = 1'b0;
        if (w_u < 14'sd0) begin
            w_uc    = 8'd0;
            w_u_sat = 1'b1;
        end else if (w_u > 14'sd255) begin
            w_uc    = 8'd255;
            w_u_sat = 1'b1;
        end
    end

`ifdef MOTOR_SLEW_LIMIT_EN
    // Step duty_next toward the clamped output by at most SLEW_STEP, never overshooting.
    always_comb begin
        w_dn_new = w_uc;
        if ({1'b0, w_uc} > {1'b0, r_duty_next} + 9'(SLEW_STEP))
            w_dn_new = r_duty_next + 8'(SLEW_STEP);
        else if ({1'b0, w_uc} + 9'(SLEW_STEP) < {1'b0, r_duty_next})
            w_dn_new = r_duty_next - 8'(SLEW_STEP);
    end
`else
    assign w_dn_new = w_uc;
`endif

    // Update FSM: one state per cycle; disable overrides everything and clears the loop.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_meas      <= 8'd0;
            r_tgt       <= 8'd0;
            r_err       <= 9'sd0;
            r_integ     <= 12'sd0;
            r_duty_next <= 8'd0;
            r_sat       <= 1'b0;
        end else if (!enable) begin
            r_state     <= IDLE;
            r_integ     <= 12'sd0;
            r_duty_next <= 8'd0;
            r_sat       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (sample_valid) begin
                        r_meas  <= pulse_data;
                        r_tgt   <= target_speed;
                        r_state <= ERR;
                    end
                end
                ERR: begin
                    r_err   <= $signed({1'b0, r_tgt}) - $signed({1'b0, r_meas});
                    r_state <= INTEG;
                end
                INTEG: begin
                    if (w_sum > w_lim)
                        r_integ <= 12'(INT_MAX);
                    else if (w_sum < -w_lim)
                        r_integ <= 12'(-INT_MAX);
                    else
                        r_integ <= w_sum[11:0];
                    r_state <= OUT;
                end
                OUT: begin
                    r_duty_next <= w_dn_new;
                    r_sat       <= w_u_sat;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_tick = (r_presc == PW'(PWM_DIV - 1));

    // Prescaler and PWM counter free-run regardless of enable.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_pwm_cnt <= 8'd0;
        end else begin
            if (w_tick) begin
                r_presc   <= '0;
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    // Duty loads only on the wrapping tick; output compare is registered to stay glitch-free.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_duty    <= 8'd0;
            r_pwm_out <= 1'b0;
        end else if (!enable) begin
            r_duty    <= 8'd0;
            r_pwm_out <= 1'b0;
        end else begin
            if (w_tick && (r_pwm_cnt == 8'd255))
                r_duty <= r_duty_next;
            r_pwm_out <= (r_pwm_cnt < r_duty);
        end
    end

    assign pwm_out   = r_pwm_out;
    assign duty      = r_duty;
    assign saturated = r_sat;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_motor_speed_ctrl.sv
// Directed bench for motor_speed_ctrl with hand-computed expectations.
module tb_motor_speed_ctrl;

    logic       clk_sys = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] target_speed;
    logic [7:0] pulse_data;
    logic       sample_valid;
    logic       pwm_out;
    logic [7:0] duty;
    logic       saturated;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int hi_cnt;

`ifdef MOTOR_SLEW_LIMIT_EN
    localparam int SLEW = 1;
`else
    localparam int SLEW = 0;
`endif

    motor_speed_ctrl dut (
        .clk_sys      (clk_sys),
        .rst_n        (rst_n),
        .enable       (enable),
        .target_speed (target_speed),
        .pulse_data   (pulse_data),
        .sample_valid (sample_valid),
        .pwm_out      (pwm_out),
        .duty         (duty),
        .saturated    (saturated),
        .busy         (busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one strobe; when dup is set a second strobe with different data follows
    // while the FSM is busy and must be ignored. Returns just after the OUT edge.
    task automatic strobe(input logic [7:0] tgt, input logic [7:0] meas, input bit dup);
        target_speed = tgt;
        pulse_data   = meas;
        sample_valid = 1'b1;
        @(posedge clk_sys); #1;
        chk("busy_after_strobe", 32'(busy), 32'd1);
        if (dup) pulse_data = 8'd0;
        else     sample_valid = 1'b0;
        @(posedge clk_sys); #1;
        sample_valid = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_duty(input string tag, input logic [7:0] exp);
        for (int i = 0; i < 1100; i++) begin
            if (duty === exp) break;
            @(posedge clk_sys); #1;
        end
        chk(tag, 32'(duty), 32'(exp));
    endtask

    task automatic count_high(output int cnt);
        cnt = 0;
        repeat (1024) begin
            @(posedge clk_sys); #1;
            if (pwm_out === 1'b1) cnt++;
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b0;
        target_speed = 8'd0;
        pulse_data   = 8'd0;
        sample_valid = 1'b0;
        #22;
        chk("rst_duty", 32'(duty), 32'd0);
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sat", 32'(saturated), 32'd0);
        rst_n = 1'b1;
        @(posedge clk_sys); #1;
        enable = 1'b1;

        // err=20: integ=20, u=40+2=42
        strobe(8'd100, 8'd80, 1'b0);
        chk("t2_integ1", 32'(dut.r_integ), 32'd20);
        chk("t2_dnext1", 32'(dut.r_duty_next), SLEW ? 32'd8 : 32'd42);
        chk("t2_busy_done", 32'(busy), 32'd0);
        wait_duty("t2_duty1", SLEW ? 8'd8 : 8'd42);
        count_high(hi_cnt);
        chk("t2_pwm_high", 32'(hi_cnt), SLEW ? 32'd32 : 32'd168);

        // second identical sample plus an ignored strobe during busy: integ=40, u=40+5=45
        strobe(8'd100, 8'd80, 1'b1);
        chk("t2_integ2", 32'(dut.r_integ), 32'd40);
        chk("t2_dnext2", 32'(dut.r_duty_next), SLEW ? 32'd16 : 32'd45);
        chk("t5_duty_held", 32'(duty), SLEW ? 32'd8 : 32'd42);
        wait_duty("t2_duty2", SLEW ? 8'd16 : 8'd45);

        // disable clears loop state on the next cycle
        enable = 1'b0;
        @(posedge clk_sys); #1;
        chk("dis_duty", 32'(duty), 32'd0);
        chk("dis_pwm", 32'(pwm_out), 32'd0);
        chk("dis_integ", 32'(dut.r_integ), 32'd0);
        chk("dis_dnext", 32'(dut.r_duty_next), 32'd0);
        enable = 1'b1;

        // err=-190: integ=-190, u=-380-24=-404 -> 0, saturated
        strobe(8'd10, 8'd200, 1'b0);
        chk("t3_integ", 32'(dut.r_integ), 32'(12'(-190)));
        chk("t3_dnext", 32'(dut.r_duty_next), 32'd0);
        chk("t3_sat", 32'(saturated), 32'd1);
        count_high(hi_cnt);
        chk("t3_pwm_low", 32'(hi_cnt), 32'd0);

        // strobe and enable falling together: sample dropped
        target_speed = 8'd255;
        pulse_data   = 8'd0;
        sample_valid = 1'b1;
        enable       = 1'b0;
        @(posedge clk_sys); #1;
        sample_valid = 1'b0;
        chk("drop_busy", 32'(busy), 32'd0);
        chk("drop_integ", 32'(dut.r_integ), 32'd0);
        chk("drop_sat", 32'(saturated), 32'd0);
        enable = 1'b1;
        @(posedge clk_sys); #1;

        // err=255 six times: integrator climbs then clamps at 1023
        for (int k = 0; k < 6; k++) begin
            int exp_i;
            exp_i = (k < 4) ? 255 * (k + 1) : 1023;
            strobe(8'd255, 8'd0, 1'b0);
            chk("t4_integ", 32'(dut.r_integ), 32'(exp_i));
            chk("t4_dnext", 32'(dut.r_duty_next), SLEW ? 32'(8 * (k + 1)) : 32'd255);
            chk("t4_sat", 32'(saturated), 32'd1);
        end
        wait_duty("t4_duty", SLEW ? 8'd48 : 8'd255);
        count_high(hi_cnt);
        chk("t4_pwm_high", 32'(hi_cnt), SLEW ? 32'd192 : 32'd1020);

        // asynchronous reset mid-period while busy and saturated
        sample_valid = 1'b1;
        @(posedge clk_sys); #2;
        sample_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_pwm", 32'(pwm_out), 32'd0);
        chk("arst_duty", 32'(duty), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_sat", 32'(saturated), 32'd0);
        chk("arst_integ", 32'(dut.r_integ), 32'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk_sys); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/motor_speed_ctrl.md
Name: motor_speed_ctrl

Overview:
Closed-loop speed regulator that consumes the 8-bit speed measurement (pulse_data) produced by the motor encoder processing stage. It compares that measurement to a commanded target and runs a multiply-free PI update each time a new sample arrives. It drives the motor H-bridge with a glitch-free PWM output whose duty is updated only at period boundaries.

Parameters:
KP_SHIFT, 1, proportional gain as left shift of error (P = error <<< KP_SHIFT)
KI_SHIFT, 3, integral gain as arithmetic right shift of integrator (I = integ >>> KI_SHIFT)
INT_MAX, 1023, symmetric integrator clamp magnitude (integ held in [-INT_MAX, +INT_MAX])
PWM_DIV, 4, clk_sys cycles per PWM counter increment (>=1)
SLEW_STEP, 8, max duty change per update (used only with MOTOR_SLEW_LIMIT_EN)

Ports:
clk_sys  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  controller run; low = motor off, integrator cleared
target_speed  input  8  commanded speed, same units as pulse_data, unsigned
pulse_data  input  8  measured speed from measurement stage, unsigned
sample_valid  input  1  one-cycle strobe: pulse_data holds a new sample
pwm_out  output  1  PWM drive to motor driver
duty  output  8  duty currently applied by the PWM generator
saturated  output  1  high when last computed output was clamped to 0 or 255
busy  output  1  high while the update FSM is not in IDLE

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, integ=0, duty_next=0, duty=0, pwm_cnt=0, prescaler=0, pwm_out=0, saturated=0, busy=0.
- FSM states IDLE, ERR, INTEG, OUT; one state per cycle.
- IDLE: on sample_valid & enable, register pulse_data and target_speed, go to ERR. Otherwise stay.
- ERR: error = target - meas, 9-bit signed (range -255..+255). Go to INTEG.
- INTEG: integ = clamp(integ + error, -INT_MAX, +INT_MAX). integ is 12-bit signed, sum is computed at 13 bits before clamping. Go to OUT.
- OUT: u = (error <<< KP_SHIFT) + (integ >>> KI_SHIFT), 14-bit signed. duty_next = clamp(u, 0, 255). saturated = (u<0)|(u>255). Return to IDLE.
- Latency: duty_next is valid 4 clk_sys cycles after the sample_valid cycle. busy is high in ERR, INTEG and OUT.
- sample_valid while busy: sample is ignored, with no queueing and no effect on the calculation in flight.
- PWM: prescaler counts 0..PWM_DIV-1 and emits a tick on wrap. pwm_cnt (8-bit) increments on each tick and wraps 255->0.
- duty <= duty_next only on the tick where pwm_cnt wraps 255->0. Duty never changes mid-period.
- pwm_out is registered: pwm_out = (pwm_cnt < duty). duty=0 gives constant low. duty=255 gives high for 255 of 256 counts.
- PWM period = 256*PWM_DIV clk_sys cycles.
- enable deasserted (any state): next cycle FSM=IDLE, integ=0, duty_next=0, duty=0, pwm_out=0, saturated=0. pwm_cnt and prescaler keep running.
- enable reasserted: resumes from integ=0 on the next sample_valid.
- sample_valid and enable falling in the same cycle: the disable wins and the sample is dropped.

Optional Feature:
MOTOR_SLEW_LIMIT_EN
- Defined: in OUT, duty_next moves toward the clamped u by at most SLEW_STEP per update, as an unsigned step with no overshoot. saturated still reflects clamping of u only.
- Undefined: duty_next = clamp(u) directly, and SLEW_STEP is unused.

Test Plan:
1. Reset mid-PWM-period with duty=128 -> pwm_out, duty, busy, saturated all 0 immediately, asynchronously, without waiting for a clock edge.
2. Defaults, enable=1, target=100, pulse_data=80, one strobe -> integ=20, u=40+2=42, duty_next=42 at +4 cycles. duty becomes 42 at the next pwm_cnt wrap. Second identical strobe -> integ=40, duty_next=45.
3. target=10, pulse_data=200 -> error=-190, u=-404, duty_next=0, saturated=1, pwm_out constantly low.
4. target=255, pulse_data=0, 6 strobes -> integ 255, 510, 765, 1020, 1023, 1023 (clamped). duty_next=255 and saturated=1 every update.
5. PWM_DIV=4, duty=64 -> pwm_out high 256 of every 1024 clk_sys cycles. Change duty_next mid-period -> old duty is held until the wrap. Strobe during busy -> ignored, result unchanged.
6. With MOTOR_SLEW_LIMIT_EN, repeat test 2 from duty 0 -> duty_next=8, then 16; enable low -> duty=0, integ=0 on the next cycle.
